// File: rtl/lcd_pkg.sv
// Shared constants and types for the LCD text path (framer and controller).
package lcd_pkg;

  localparam int LCD_NUM_DATA_ALL     = 32;
  localparam int LCD_NUM_DATA_PERLINE = 16;
  localparam int LCD_DATA_BITS        = 8;

  // Character codes interpreted by the framer
  localparam logic [7:0] CHAR_SPACE = 8'h20;
  localparam logic [7:0] CHAR_LF    = 8'h0A;
  localparam logic [7:0] CHAR_CR    = 8'h0D;
  localparam logic [7:0] CHAR_FF    = 8'h0C;

  // HD44780-style command bytes used by LCD1602_controller
  localparam logic [7:0] CMD_CLEAR        = 8'h01;
  localparam logic [7:0] CMD_HOME         = 8'h02;
  localparam logic [7:0] CMD_ENTRY_MODE   = 8'h06;
  localparam logic [7:0] CMD_DISPLAY_ON   = 8'h0C;
  localparam logic [7:0] CMD_FUNCTION_SET = 8'h38;
  localparam logic [7:0] CMD_LINE1_ADDR   = 8'h80;
  localparam logic [7:0] CMD_LINE2_ADDR   = 8'hC0;

  typedef enum logic [1:0] {
    CLEAR     = 2'd0,
    FILL      = 2'd1,
    SWAP_WAIT = 2'd2,
    SWAP      = 2'd3
  } framer_state_e;

endpackage

// File: rtl/lcd_frame_ram.sv
// Two-bank character store: synchronous write into the back bank,
// asynchronous read from the front bank.
module lcd_frame_ram #(
  parameter int NUM_DATA_ALL = 32,
  parameter int DATA_BITS    = 8
) (
  input  logic                            clk,
  input  logic                            front_sel,
  input  logic                            wr_en,
  input  logic [$clog2(NUM_DATA_ALL)-1:0] wr_addr,
  input  logic [DATA_BITS-1:0]            wr_data,
  input  logic [$clog2(NUM_DATA_ALL)-1:0] rd_addr,
  output logic [DATA_BITS-1:0]            rd_data
);

  logic [DATA_BITS-1:0] mem [2*NUM_DATA_ALL];

  // Writes always land in the bank the reader is not looking at
  always_ff @(posedge clk) begin
    if (wr_en) mem[{~front_sel, wr_addr}] <= wr_data;
  end

  assign rd_data = mem[{front_sel, rd_addr}];

endmodule

// File: rtl/lcd_text_framer.sv
// Builds a two-line text frame from a byte stream and commits it by bank swap.
//
// state     | meaning
// ----------|------------------------------------------------------------
// CLEAR     | blank back bank, one cell per cycle, in_ready low
// FILL      | accept bytes, interpret LF/CR/FF, write printable chars
// SWAP_WAIT | frame complete, hold off until consumer drops rd_lock
// SWAP      | one cycle; swap banks on exit, pulse commit_o, set ready_o
module lcd_text_framer
  import lcd_pkg::*;
#(
  parameter int NUM_DATA_ALL     = LCD_NUM_DATA_ALL,
  parameter int NUM_DATA_PERLINE = LCD_NUM_DATA_PERLINE,
  parameter int DATA_BITS        = LCD_DATA_BITS
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [DATA_BITS-1:0]            in_data,
  input  logic                            rd_lock,
  input  logic [$clog2(NUM_DATA_ALL)-1:0] rd_addr,
  output logic [DATA_BITS-1:0]            rd_data,
  output logic                            ready_o,
  output logic                            commit_o
);

  localparam int AW = $clog2(NUM_DATA_ALL);
  localparam logic [AW-1:0] LAST_IDX  = AW'(NUM_DATA_ALL - 1);
  localparam logic [AW-1:0] LINE2_IDX = AW'(NUM_DATA_PERLINE);

  framer_state_e        state, state_nxt;
  logic [AW-1:0]        clr_cnt, clr_cnt_nxt;
  logic [AW-1:0]        cursor, cursor_nxt;
  logic                 front_sel;
  logic                 wr_en;
  logic [AW-1:0]        wr_addr;
  logic [DATA_BITS-1:0] wr_data;

  // State, counters and bank flags; swap-side effects happen on the SWAP exit edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= CLEAR;
      clr_cnt   <= '0;
      cursor    <= '0;
      front_sel <= 1'b0;
      ready_o   <= 1'b0;
      commit_o  <= 1'b0;
    end else begin
      state     <= state_nxt;
      clr_cnt   <= clr_cnt_nxt;
      cursor    <= cursor_nxt;
      front_sel <= front_sel ^ (state == SWAP);
      ready_o   <= ready_o | (state == SWAP);
      commit_o  <= (state == SWAP);
    end
  end

  // Next-state, write-port control and handshake
  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    cursor_nxt  = cursor;
    wr_en       = 1'b0;
    wr_addr     = cursor;
    wr_data     = in_data;
    in_ready    = 1'b0;
    unique case (state)
      CLEAR: begin
        wr_en       = 1'b1;
        wr_addr     = clr_cnt;
        wr_data     = DATA_BITS'(CHAR_SPACE);
        clr_cnt_nxt = clr_cnt + 1'b1;
        if (clr_cnt == LAST_IDX) begin
          state_nxt   = FILL;
          clr_cnt_nxt = '0;
          cursor_nxt  = '0;
        end
      end
      FILL: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (in_data == DATA_BITS'(CHAR_LF)) begin
            if (cursor < LINE2_IDX) cursor_nxt = LINE2_IDX;
            else                    state_nxt  = SWAP_WAIT;
          end else if (in_data == DATA_BITS'(CHAR_CR)) begin
            state_nxt = SWAP_WAIT;
          end else if (in_data == DATA_BITS'(CHAR_FF)) begin
            state_nxt   = CLEAR;
            clr_cnt_nxt = '0;
            cursor_nxt  = '0;
          end else begin
            wr_en = 1'b1;
            // Terminal compare before increment: cursor never shows a wrap in FILL
            if (cursor == LAST_IDX) begin
              state_nxt  = SWAP_WAIT;
              cursor_nxt = '0;
            end else begin
              cursor_nxt = cursor + 1'b1;
            end
          end
        end
      end
      SWAP_WAIT: begin
        if (!rd_lock) state_nxt = SWAP;
      end
      SWAP: begin
        state_nxt = CLEAR;
      end
      default: state_nxt = CLEAR;
    endcase
  end

  lcd_frame_ram #(
    .NUM_DATA_ALL (NUM_DATA_ALL),
    .DATA_BITS    (DATA_BITS)
  ) u_ram (
    .clk       (clk),
    .front_sel (front_sel),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data)
  );

endmodule

// File: tb/tb_lcd_text_framer.sv
// Directed self-checking bench for lcd_text_framer.
module tb_lcd_text_framer;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       rd_lock;
  logic [4:0] rd_addr;
  logic [7:0] rd_data;
  logic       ready_o;
  logic       commit_o;

  int checks   = 0;
  int failures = 0;
  int commit_cnt = 0;

  lcd_text_framer dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .rd_lock  (rd_lock),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .ready_o  (ready_o),
    .commit_o (commit_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (commit_o === 1'b1) commit_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    check("send_in_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic rd_check(input string tag, input int addr, input logic [7:0] exp);
    rd_addr = 5'(addr);
    #1;
    check(tag, {24'd0, rd_data}, {24'd0, exp});
  endtask

  task automatic wait_in_ready(input string tag, input int exp_n);
    int m = 0;
    while (in_ready !== 1'b1 && m < 100) begin
      @(posedge clk); #1;
      m++;
      if (m == 1) check({tag, "_pulse_width"}, {31'd0, commit_o}, 32'd0);
    end
    check({tag, "_clear_cycles"}, m, exp_n);
  endtask

  // Called right after the accepting edge (+1); counts edges to commit_o
  task automatic expect_commit(input string tag, input int exp_n);
    int n = 0;
    while (commit_o !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_commit_lat"}, n, exp_n);
    check({tag, "_ready_o"}, {31'd0, ready_o}, 32'd1);
    wait_in_ready(tag, 32);
  endtask

  initial begin
    int c0;
    reset    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    rd_lock  = 1'b0;
    rd_addr  = 5'd0;
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_ready_o",  {31'd0, ready_o},  32'd0);
    check("rst_commit_o", {31'd0, commit_o}, 32'd0);

    // Reset release: in_ready only after 32 CLEAR edges
    @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      @(posedge clk); #1;
      check($sformatf("boot_in_ready_%0d", i), {31'd0, in_ready}, (i == 32) ? 32'd1 : 32'd0);
      check($sformatf("boot_ready_o_%0d", i), {31'd0, ready_o}, 32'd0);
    end

    // "HELLO" CR
    send(8'h48); send(8'h45); send(8'h4C); send(8'h4C); send(8'h4F); send(8'h0D);
    expect_commit("hello", 2);
    rd_check("hello_0", 0, 8'h48);
    rd_check("hello_1", 1, 8'h45);
    rd_check("hello_2", 2, 8'h4C);
    rd_check("hello_3", 3, 8'h4C);
    rd_check("hello_4", 4, 8'h4F);
    for (int a = 5; a < 32; a++) rd_check($sformatf("hello_sp_%0d", a), a, 8'h20);

    // "AB" LF "CD" CR
    send(8'h41); send(8'h42); send(8'h0A); send(8'h43); send(8'h44); send(8'h0D);
    expect_commit("ablf", 2);
    for (int a = 0; a < 32; a++) begin
      logic [7:0] e;
      e = (a == 0) ? 8'h41 : (a == 1) ? 8'h42 : (a == 16) ? 8'h43 : (a == 17) ? 8'h44 : 8'h20;
      rd_check($sformatf("ablf_%0d", a), a, e);
    end

    // 32 bytes with rd_lock held for 10 cycles after the auto-commit point
    rd_lock = 1'b1;
    for (int i = 0; i < 32; i++) send(8'(8'h41 + i));
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check($sformatf("lock_no_commit_%0d", i), {31'd0, commit_o}, 32'd0);
      rd_check($sformatf("lock_front16_%0d", i), 16, 8'h43);
      rd_check($sformatf("lock_front5_%0d", i), 5, 8'h20);
    end
    rd_lock = 1'b0;
    expect_commit("full", 2);
    for (int a = 0; a < 32; a++) rd_check($sformatf("full_%0d", a), a, 8'(8'h41 + a));

    // "XYZ" FF "Q" CR: FF discards the back bank without a swap
    c0 = commit_cnt;
    send(8'h58); send(8'h59); send(8'h5A); send(8'h0C);
    wait_in_ready("ff", 32);
    check("ff_no_commit", commit_cnt - c0, 0);
    send(8'h51); send(8'h0D);
    expect_commit("ffq", 2);
    check("ffq_one_commit", commit_cnt - c0, 1);
    rd_check("ffq_0", 0, 8'h51);
    rd_check("ffq_1", 1, 8'h20);
    rd_check("ffq_2", 2, 8'h20);
    rd_check("ffq_16", 16, 8'h20);
    rd_check("ffq_31", 31, 8'h20);

    // LF at cursor 0 jumps to line 2; LF on line 2 commits
    send(8'h0A); send(8'h5A); send(8'h0A);
    expect_commit("lf2", 2);
    rd_check("lf2_0", 0, 8'h20);
    rd_check("lf2_15", 15, 8'h20);
    rd_check("lf2_16", 16, 8'h5A);
    rd_check("lf2_17", 17, 8'h20);

    // Reset in the middle of FILL after 10 bytes
    for (int i = 0; i < 10; i++) send(8'(8'h30 + i));
    check("pre_rst_ready_o", {31'd0, ready_o}, 32'd1);
    reset = 1'b0;
    #1;
    check("mid_rst_ready_o",  {31'd0, ready_o},  32'd0);
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("mid_rst_commit_o", {31'd0, commit_o}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    wait_in_ready("rerst", 32);
    check("rerst_ready_o", {31'd0, ready_o}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
